// File: rtl/fir_output_requant.sv
// Requantizes the FIR accumulator stream to OUT_W bits (round, shift, saturate, decimate) into a show-ahead FIFO.
// Optional macro REQUANT_SAT_CNT_EN enables the saturation event counter on sat_cnt.
module fir_output_requant #(
   parameter int IN_W       = 64,
   parameter int OUT_W      = 16,
   parameter int SHIFT      = 15,
   parameter int DECIM      = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    din_valid,
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout,
   output logic                    dout_valid,
   input  logic                    dout_ready,
   output logic                    sat_flag,
   output logic [15:0]             drop_cnt,
   output logic [15:0]             sat_cnt
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CW   = AW + 1;
   localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

   localparam logic [PH_W-1:0]         PH_LAST = PH_W'(DECIM - 1);
   localparam logic [CW-1:0]           FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic signed [IN_W:0]    RND  = (IN_W + 1)'(1) << (SHIFT - 1);
   localparam logic signed [OUT_W-1:0] OMAX = {1'b0, {(OUT_W - 1){1'b1}}};
   localparam logic signed [OUT_W-1:0] OMIN = {1'b1, {(OUT_W - 1){1'b0}}};
   localparam logic signed [IN_W:0]    RMAX = {{(IN_W + 1 - OUT_W){1'b0}}, OMAX};
   localparam logic signed [IN_W:0]    RMIN = {{(IN_W + 1 - OUT_W){1'b1}}, OMIN};

   // One guard bit keeps the rounding add from wrapping at the top of the input range.
   function automatic logic signed [IN_W:0] round_shift(input logic signed [IN_W-1:0] x);
      logic signed [IN_W:0] sum;
      sum = $signed({x[IN_W-1], x}) + RND;
      return sum >>> SHIFT;
   endfunction

   // Returns {clip, value}.
   function automatic logic [OUT_W:0] saturate(input logic signed [IN_W:0] r);
      if (r > RMAX)
         return {1'b1, OMAX};
      else if (r < RMIN)
         return {1'b1, OMIN};
      else
         return {1'b0, r[OUT_W-1:0]};
   endfunction

   logic signed [IN_W-1:0]  din_p0;
   logic signed [IN_W:0]    r_p1;
   logic signed [OUT_W-1:0] dat_p2;
   logic                    clip_p2;
   logic                    vld_p0, vld_p1, vld_p2;

   logic [PH_W-1:0]         phase;
   logic signed [OUT_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]           rd_ptr, wr_ptr, rd_next;
   logic [CW-1:0]           count, count_next;
   logic signed [OUT_W-1:0] head_next;
   logic                    push, pop, full, push_ok, drop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p0 <= din_valid;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
      end
   end

   // p0: input capture -> p1: round/shift -> p2: saturate
   always_ff @(posedge clk) begin
      if (din_valid)
         din_p0 <= din;
      if (vld_p0)
         r_p1 <= round_shift(din_p0);
      if (vld_p1)
         {clip_p2, dat_p2} <= saturate(r_p1);
   end

   // p2 -> FIFO: decimate, push/pop bookkeeping
   assign push    = vld_p2 && (phase == '0);
   assign pop     = dout_valid && dout_ready;
   assign full    = (count == FULL_CNT);
   assign push_ok = push && (!full || pop);
   assign drop    = push && full && !pop;

   always_comb begin
      rd_next    = pop ? rd_ptr + 1'b1 : rd_ptr;
      count_next = count + CW'(push_ok) - CW'(pop);
      head_next  = dout;
      if (count_next != '0) begin
         if (push_ok && (wr_ptr == rd_next))
            head_next = dat_p2;
         else
            head_next = mem[rd_next];
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= dat_p2;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase      <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         sat_flag   <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         if (vld_p2)
            phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
         if (push_ok) begin
            wr_ptr   <= wr_ptr + 1'b1;
            sat_flag <= clip_p2;
         end
         rd_ptr     <= rd_next;
         count      <= count_next;
         dout       <= head_next;
         dout_valid <= (count_next != '0);
         if (drop && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 1'b1;
      end
   end

`ifdef REQUANT_SAT_CNT_EN
   // Counts every clamped p2 sample, including ones later decimated away or dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         sat_cnt <= '0;
      else if (vld_p2 && clip_p2 && (sat_cnt != 16'hFFFF))
         sat_cnt <= sat_cnt + 1'b1;
   end
`else
   assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_fir_output_requant.sv
// Bench for fir_output_requant: two instances (DECIM=1 and DECIM=4) against a queue-based reference model.
module tb_fir_output_requant;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               din_valid;
   logic signed [63:0] din;
   logic               rdy0, rdy1;
   logic signed [15:0] dout0, dout1;
   logic               dv0, dv1, sf0, sf1;
   logic [15:0]        dc0, dc1, sc0, sc1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fir_output_requant #(.IN_W(64), .OUT_W(16), .SHIFT(15), .DECIM(1), .FIFO_DEPTH(8)) u_d1 (
      .clk(clk), .rst(rst_n), .din_valid(din_valid), .din(din),
      .dout(dout0), .dout_valid(dv0), .dout_ready(rdy0),
      .sat_flag(sf0), .drop_cnt(dc0), .sat_cnt(sc0));

   fir_output_requant #(.IN_W(64), .OUT_W(16), .SHIFT(15), .DECIM(4), .FIFO_DEPTH(8)) u_d4 (
      .clk(clk), .rst(rst_n), .din_valid(din_valid), .din(din),
      .dout(dout1), .dout_valid(dv1), .dout_ready(rdy1),
      .sat_flag(sf1), .drop_cnt(dc1), .sat_cnt(sc1));

   typedef struct {
      bit                 v;
      logic signed [15:0] val;
      bit                 clip;
   } samp_t;

   samp_t dl [3];
   samp_t q0 [$];
   samp_t q1 [$];
   int    ph  [2];
   int    drp [2];
   bit    sfl [2];
   int    sct [2];
   logic signed [15:0] got0 [$];
   logic signed [15:0] got1 [$];

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Round half up on a divide by 2^15, then clamp to 16-bit signed.
   function automatic samp_t ref_s(input logic signed [63:0] d, input bit v);
      samp_t  s;
      longint q, rem, r;
      q   = longint'(d) >>> 15;
      rem = longint'(d) & 64'sd32767;
      r   = q + ((rem >= 16384) ? 64'sd1 : 64'sd0);
      s.v = v;
      s.clip = 1'b0;
      if (r > 32767) begin
         r = 32767;
         s.clip = 1'b1;
      end else if (r < -32768) begin
         r = -32768;
         s.clip = 1'b1;
      end
      s.val = 16'(r);
      return s;
   endfunction

   function automatic int qsize(input int k);
      return (k == 0) ? q0.size() : q1.size();
   endfunction

   task automatic fifo_edge(input int k, input bit rdy, input samp_t e);
      int sz;
      bit pop;
      sz  = qsize(k);
      pop = (sz > 0) && rdy;
      if (e.v) begin
         if (e.clip && sct[k] < 65535) sct[k]++;
         if (ph[k] == 0) begin
            if (sz < 8 || pop) begin
               if (pop) begin
                  if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                  pop = 1'b0;
               end
               if (k == 0) q0.push_back(e); else q1.push_back(e);
               sfl[k] = e.clip;
            end else if (drp[k] < 65535) begin
               drp[k]++;
            end
         end
         ph[k] = (ph[k] + 1) % ((k == 0) ? 1 : 4);
      end
      if (pop) begin
         if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
   endtask

   task automatic model_edge();
      samp_t e;
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) dl[i] = '{v: 1'b0, val: '0, clip: 1'b0};
         q0.delete();
         q1.delete();
         for (int k = 0; k < 2; k++) begin
            ph[k] = 0; drp[k] = 0; sfl[k] = 1'b0; sct[k] = 0;
         end
      end else begin
         e = dl[2];
         dl[2] = dl[1];
         dl[1] = dl[0];
         dl[0] = ref_s(din, din_valid);
         fifo_edge(0, rdy0, e);
         fifo_edge(1, rdy1, e);
      end
   endtask

   task automatic chk_dut(input int k, input logic signed [15:0] d, input logic v,
                          input logic sf, input logic [15:0] dc, input logic [15:0] sc);
      string p;
      int    sz;
      p  = (k == 0) ? "d1" : "d4";
      sz = qsize(k);
      chk({p, "_dout_valid"}, v, (sz > 0) ? 1 : 0);
      if (sz > 0) chk({p, "_dout"}, d, (k == 0) ? q0[0].val : q1[0].val);
      chk({p, "_sat_flag"}, sf, sfl[k]);
      chk({p, "_drop_cnt"}, dc, drp[k]);
`ifdef REQUANT_SAT_CNT_EN
      chk({p, "_sat_cnt"}, sc, sct[k]);
`else
      chk({p, "_sat_cnt"}, sc, 0);
`endif
   endtask

   task automatic step();
      if (rst_n) begin
         if (dv0 && rdy0) got0.push_back(dout0);
         if (dv1 && rdy1) got1.push_back(dout1);
      end
      @(posedge clk);
      model_edge();
      #1;
      chk_dut(0, dout0, dv0, sf0, dc0, sc0);
      chk_dut(1, dout1, dv1, sf1, dc1, sc1);
   endtask

   task automatic send(input logic signed [63:0] d);
      din_valid = 1'b1;
      din = d;
      step();
      din_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      din_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_dout0"}, dout0, 0);
      chk({tag, "_dv0"}, dv0, 0);
      chk({tag, "_sf0"}, sf0, 0);
      chk({tag, "_dc0"}, dc0, 0);
      chk({tag, "_sc0"}, sc0, 0);
      chk({tag, "_dout1"}, dout1, 0);
      chk({tag, "_dv1"}, dv1, 0);
      chk({tag, "_sf1"}, sf1, 0);
      chk({tag, "_dc1"}, dc1, 0);
      chk({tag, "_sc1"}, sc1, 0);
   endtask

   initial begin
      logic signed [63:0] rnd_in [5];
      logic signed [15:0] rnd_exp [5];
      logic signed [63:0] r;
      int sh;

      rst_n = 1'b0; din_valid = 1'b0; din = '0; rdy0 = 1'b1; rdy1 = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk_zero_outputs("reset");
      rst_n = 1'b1;
      idle(3);

      // Rounding
      rnd_in  = '{64'sd16383, 64'sd16384, 64'sd32768, -64'sd16384, -64'sd16385};
      rnd_exp = '{16'sd0, 16'sd1, 16'sd1, 16'sd0, -16'sd1};
      got0.delete();
      for (int i = 0; i < 5; i++) send(rnd_in[i]);
      idle(6);
      chk("round_count", got0.size(), 5);
      for (int i = 0; i < 5 && i < got0.size(); i++) chk("round_val", got0[i], rnd_exp[i]);

      // Saturation, including the extreme positive input
      got0.delete();
      send(64'sd1 <<< 40);
      send(-(64'sd1 <<< 40));
      idle(6);
      chk("sat_count", got0.size(), 2);
      if (got0.size() == 2) begin
         chk("sat_hi", got0[0], 32767);
         chk("sat_lo", got0[1], -32768);
      end
      chk("sat_flag", sf0, 1);
`ifdef REQUANT_SAT_CNT_EN
      chk("sat_cnt", sc0, 2);
`else
      chk("sat_cnt", sc0, 0);
`endif
      send(64'sh7FFF_FFFF_FFFF_FFFF);
      idle(5);

      // Decimation by 4 with an idle gap mid-stream
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      got1.delete();
      for (int i = 0; i < 12; i++) begin
         if (i == 6) idle(1);
         send(longint'(i) <<< 15);
      end
      idle(8);
      chk("decim_count", got1.size(), 3);
      for (int i = 0; i < 3 && i < got1.size(); i++) chk("decim_val", got1[i], 4 * i);

      // Overflow into a stalled FIFO
      rdy0 = 1'b0;
      for (int i = 0; i < 10; i++) send(longint'(100 + i) <<< 15);
      idle(5);
      chk("ovf_drop", dc0, 2);
      chk("ovf_valid", dv0, 1);
      chk("ovf_head", dout0, 100);

      // Push meeting a pop while full
      send(longint'(200) <<< 15);
      idle(2);
      rdy0 = 1'b1;
      idle(1);
      rdy0 = 1'b0;
      chk("pushpop_drop", dc0, 2);
      chk("pushpop_head", dout0, 101);

      got0.delete();
      rdy0 = 1'b1;
      idle(10);
      chk("drain_count", got0.size(), 8);
      for (int i = 0; i < 8 && i < got0.size(); i++)
         chk("drain_val", got0[i], (i < 7) ? 101 + i : 200);

      // Asynchronous reset in the middle of traffic
      rdy0 = 1'b0; rdy1 = 1'b0;
      for (int i = 0; i < 9; i++) send(longint'(i + 1) <<< 16);
      send(64'sd1 <<< 45);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero_outputs("async_rst");
      step();
      step();
      rst_n = 1'b1;
      idle(4);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         din_valid = ($urandom_range(0, 3) != 0);
         sh = $urandom_range(0, 55);
         r = $signed({$urandom, $urandom});
         din = r >>> sh;
         if ($urandom_range(0, 31) == 0) din = 64'sh7FFF_FFFF_FFFF_FFFF;
         if ($urandom_range(0, 31) == 0) din = 64'sh8000_0000_0000_0000;
         rdy0 = ($urandom_range(0, 1) == 1);
         rdy1 = ($urandom_range(0, 3) == 0);
         step();
      end
      rdy0 = 1'b1; rdy1 = 1'b1;
      idle(12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fir_output_requant.md
# fir_output_requant

Downstream stage of the pipelined FIR filter: consumes the filter's 64-bit signed accumulator output and turns it into a 16-bit stream.
- Rounds and shifts each sample, saturates it to the output width and decimates the stream.
- Buffers the result in a small FIFO behind a valid/ready handshake for the DAC/capture side.
- Counts dropped samples so that overruns are visible in simulation and on hardware.

## Interface
- IN_W, 64, input sample width (signed, matches FIR dout)
- OUT_W, 16, output sample width (signed)
- SHIFT, 15, right-shift applied after rounding (1..IN_W-OUT_W)
- DECIM, 4, decimation factor (1 = pass every sample)
- FIFO_DEPTH, 8, output FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- din_valid  in  1  din carries a new FIR output this cycle
- din  in  IN_W  signed FIR accumulator output
- dout  out  OUT_W  signed requantized sample (FIFO head)
- dout_valid  out  1  FIFO non-empty
- dout_ready  in  1  consumer accepts dout this cycle
- sat_flag  out  1  last sample written to the FIFO was clipped
- drop_cnt  out  16  count of decimated samples lost to a full FIFO, saturating at 0xFFFF
- sat_cnt  out  16  saturation event count (see Configuration)

## Operation
- S1 (round): on din_valid, register r = (din + 2^(SHIFT-1)) >>> SHIFT.
  - The add is computed in IN_W+1 bits, so there is no wrap.
  - Rounding is round-half-up; the shift is arithmetic.
- S2 (saturate): clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Set the clip bit if r was clamped.
  - S2 keeps the valid bit from S1.
- Decimator: phase counter 0..DECIM-1, reset to 0.
  - It advances on each valid S2 sample and wraps from DECIM-1 to 0.
  - Only a sample arriving with phase 0 is pushed.
- FIFO: show-ahead.
  - dout is the head entry whenever dout_valid=1.
  - A pop happens when dout_valid && dout_ready.
- Push while full:
  - If a pop happens in the same cycle, the push is accepted.
  - Otherwise the sample is discarded and drop_cnt increments.
- Empty FIFO: a push sets dout_valid on the next cycle. No pop can occur while empty.
- sat_flag updates only on an accepted push.
- drop_cnt and sat_cnt saturate at 0xFFFF and never wrap.
- Reset, including mid-operation:
  - Pipeline valid bits, phase, FIFO pointers and counters all clear.
  - dout=0, dout_valid=0, sat_flag=0, drop_cnt=0, sat_cnt=0.
  - In-flight and buffered samples are lost.

## Timing
- Latency: din_valid sampled on edge N → S1 at N+1 → S2/push at N+2 → dout_valid=1 after edge N+3 (empty FIFO).
- Full throughput: one din per cycle, no backpressure to the FIR. Overflow is handled only by dropping.
- All outputs are registered, and dout_valid has no combinational path from dout_ready.
- The decimator phase does not advance on cycles with no valid S2 sample.

## Configuration
- REQUANT_SAT_CNT_EN defined:
  - sat_cnt counts S2 samples that were clamped, whether or not they are decimated or dropped.
  - The counter is 16-bit and saturating.
- Not defined:
  - The counter logic is compiled out and sat_cnt is tied to 0.
  - sat_flag is unaffected.

## Test plan
- Reset/idle: rst=0 for 3 cycles → all outputs 0. Release with din_valid=0 → dout_valid stays 0.
- Rounding (DECIM=1, SHIFT=15, ready=1): din = 16383, 16384, 32768, −16384, −16385 → dout = 0, 1, 1, 0, −1, each appearing 3 cycles after its input.
- Saturation: din = 2^40, then −2^40 → dout = 32767 then −32768, sat_flag=1 on both; sat_cnt=2 with REQUANT_SAT_CNT_EN, else 0.
- Decimation (DECIM=4): 12 consecutive valid ramps 0..11 × 2^15 → dout = 0, 4, 8 only. An idle cycle inserted mid-stream does not shift the phase.
- Overflow (DECIM=1, depth 8, ready=0): 10 valid samples → dout_valid=1, FIFO holds the first 8, drop_cnt=2. Then ready=1 → the 8 samples drain in order.
- Full push/pop and async reset: with the FIFO full, a push coinciding with a pop is accepted and drop_cnt is unchanged. Asserting rst mid-stream → outputs clear immediately, without waiting for clk.
